pktbuf_rd_arbiter: RTL and testbench

// - Shares the single eSRAM packet-buffer read port among NUM_REQ requesters, all in the clk_esram domain.
// - Grants reads round-robin and issues rden/rdaddress.
// - Tracks in-flight reads in a tag FIFO and returns each rd_valid/rddata beat with the requester id.
// - Sits between the packet-buffer consumers and the esram_wrapper read port.

---
 rtl/pktbuf_rd_arbiter.sv | 165 ++++++++++++++++
 tb/tb_pktbuf_rd_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pktbuf_rd_arbiter.sv
// Round-robin arbiter for the single eSRAM packet-buffer read port; a tag FIFO routes each
// returning beat back to its requester. Optional counters under PKTBUF_RD_STATS_EN.
module pktbuf_rd_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int AWIDTH          = 16,
  parameter int DWIDTH          = 520,
  parameter int TAG_DEPTH       = 16,
  parameter int MAX_OUTSTANDING = 16,
  parameter int DRAIN_CYCLES    = 16
) (
  input  logic                         clk_esram_i,
  input  logic                         rst_n_i,
  input  logic                         esram_pll_lock_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ*AWIDTH-1:0]    req_addr_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic                         rden_o,
  output logic [AWIDTH-1:0]            rdaddress_o,
  input  logic                         rd_valid_i,
  input  logic [DWIDTH-1:0]            rddata_i,
  output logic                         rsp_valid_o,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id_o,
  output logic [DWIDTH-1:0]            rsp_data_o,
  output logic                         err_underflow_o
`ifdef PKTBUF_RD_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]        stat_grants_o,
  output logic [31:0]                  stat_full_cycles_o
`endif
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = $clog2(TAG_DEPTH);
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int DCW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [CW-1:0]  MAXO  = CW'(MAX_OUTSTANDING);
  localparam logic [DCW-1:0] DRAIN = DCW'(DRAIN_CYCLES);
  localparam logic [IDW-1:0] LAST  = IDW'(NUM_REQ - 1);

  logic [IDW-1:0]    rr_q, rr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DCW-1:0]    drain_q;
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [IDW-1:0]    tag_mem [TAG_DEPTH];
  logic [AWIDTH-1:0] addr_a [NUM_REQ];

  logic              rden_q, rsp_valid_q, err_q;
  logic [AWIDTH-1:0] rdaddress_q;
  logic [IDW-1:0]    rsp_id_q;
  logic [DWIDTH-1:0] rsp_data_q;

  logic [IDW-1:0]    hi_id, lo_id, win_id;
  logic              hi_found, lo_found, win_found;
  logic              drained, eligible, xfer, pop, underflow;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign addr_a[g] = req_addr_i[g*AWIDTH +: AWIDTH];
  end

  assign drained  = (drain_q == '0);
  assign eligible = rst_n_i && esram_pll_lock_i && drained && (cnt_q < MAXO);

  // Two priority passes: first valid at/after the pointer, else first valid from 0 (the wrap).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hi_found && req_valid_i[i] && (IDW'(i) >= rr_q)) begin
        hi_found = 1'b1;
        hi_id    = IDW'(i);
      end
      if (!lo_found && req_valid_i[i]) begin
        lo_found = 1'b1;
        lo_id    = IDW'(i);
      end
    end
    win_found = hi_found || lo_found;
    win_id    = hi_found ? hi_id : lo_id;
  end

  assign xfer        = eligible && win_found;
  assign req_ready_o = xfer ? (NUM_REQ'(1) << win_id) : '0;
  // Returns during the drain window belong to reads issued before reset; drop them silently.
  assign pop         = rd_valid_i && drained && (cnt_q != '0);
  assign underflow   = rd_valid_i && drained && (cnt_q == '0);

  always_comb begin
    rr_d = rr_q;
    if (xfer) rr_d = (win_id == LAST) ? '0 : win_id + IDW'(1);
    cnt_d = cnt_q;
    case ({xfer, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_esram_i) begin
    if (!rst_n_i) begin
      rr_q        <= '0;
      cnt_q       <= '0;
      drain_q     <= DRAIN;
      wptr_q      <= '0;
      rptr_q      <= '0;
      rden_q      <= 1'b0;
      rdaddress_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      if (!drained) drain_q <= drain_q - DCW'(1);
      rden_q      <= xfer;
      if (xfer) begin
        rdaddress_q <= addr_a[win_id];
        wptr_q      <= wptr_q + PW'(1);
      end
      rsp_valid_q <= pop;
      if (pop) begin
        rsp_id_q   <= tag_mem[rptr_q];
        rsp_data_q <= rddata_i;
        rptr_q     <= rptr_q + PW'(1);
      end
      if (underflow) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_esram_i) begin
    if (xfer) tag_mem[wptr_q] <= win_id;
  end

  assign rden_o          = rden_q;
  assign rdaddress_o     = rdaddress_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_id_o        = rsp_id_q;
  assign rsp_data_o      = rsp_data_q;
  assign err_underflow_o = err_q;

`ifdef PKTBUF_RD_STATS_EN
  logic [NUM_REQ-1:0][31:0] grants_q;
  logic [31:0]              full_q;

  always_ff @(posedge clk_esram_i) begin
    if (!rst_n_i) begin
      grants_q <= '0;
      full_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready_o[i] && req_valid_i[i] && (grants_q[i] != '1))
          grants_q[i] <= grants_q[i] + 32'd1;
      end
      if ((cnt_q == MAXO) && (|req_valid_i) && (full_q != '1))
        full_q <= full_q + 32'd1;
    end
  end

  assign stat_grants_o      = grants_q;
  assign stat_full_cycles_o = full_q;
`endif

endmodule

// File: tb/tb_pktbuf_rd_arbiter.sv
// Bench for pktbuf_rd_arbiter: queue-based reference model plus a latency-programmable memory.
module tb_pktbuf_rd_arbiter;
  localparam int NR = 4, AW = 16, DW = 520, TD = 32, MO = 16, DC = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, lock, rd_valid;
  logic [NR-1:0]      req_valid, req_ready;
  logic [NR*AW-1:0]   req_addr;
  logic [AW-1:0]      addr [NR];
  logic               rden, rsp_valid, err;
  logic [AW-1:0]      rdaddress;
  logic [DW-1:0]      rddata, rsp_data;
  logic [1:0]         rsp_id;
`ifdef PKTBUF_RD_STATS_EN
  logic [NR*32-1:0]   stat_grants;
  logic [31:0]        stat_full;
`endif

  pktbuf_rd_arbiter #(
    .NUM_REQ(NR), .AWIDTH(AW), .DWIDTH(DW), .TAG_DEPTH(TD),
    .MAX_OUTSTANDING(MO), .DRAIN_CYCLES(DC)
  ) dut (
    .clk_esram_i(clk), .rst_n_i(rst_n), .esram_pll_lock_i(lock),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(req_ready),
    .rden_o(rden), .rdaddress_o(rdaddress), .rd_valid_i(rd_valid), .rddata_i(rddata),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_data_o(rsp_data),
    .err_underflow_o(err)
`ifdef PKTBUF_RD_STATS_EN
    , .stat_grants_o(stat_grants), .stat_full_cycles_o(stat_full)
`endif
  );

  always_comb begin
    req_addr = '0;
    for (int g = 0; g < NR; g++) req_addr[g*AW +: AW] = addr[g];
  end

  int total = 0, bad = 0, cyc = 0;
  bit chk_en = 0;

  // memory: a read seen on rden in cycle C returns in cycle C+lat
  bit            ret_v [256];
  logic [DW-1:0] ret_d [256];
  int            lat = 12;
  bit            inject = 0;

  // reference model state
  int            q[$];
  int            m_rr = 0, m_drain = DC, m_g1 = 0;
  bit            e_rden = 0, e_rv = 0, e_err = 0;
  logic [AW-1:0] e_addr = '0;
  int            e_id = 0;
  logic [DW-1:0] e_data = '0;

  // per-tick DUT samples for literal checks
  int dx, gid, rs;

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int oh2id(logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic mem_drive();
    int s;
    logic [543:0] tmp;
    if (rden === 1'b1) begin
      s = (cyc + lat) % 256;
      for (int w = 0; w < 17; w++) tmp[w*32 +: 32] = $urandom;
      ret_v[s] = 1'b1;
      ret_d[s] = tmp[DW-1:0];
    end
    s = cyc % 256;
    rd_valid = ret_v[s] | inject;
    rddata   = ret_v[s] ? ret_d[s] : '0;
    ret_v[s] = 1'b0;
  endtask

  task automatic model_step();
    bit            elig;
    int            w;
    logic [NR-1:0] e_rdy;
    elig  = rst_n && lock && (q.size() < MO) && (m_drain == 0);
    w     = -1;
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (m_rr + k) % NR;
      if (w < 0 && req_valid[idx]) w = idx;
    end
    e_rdy = '0;
    if (elig && w >= 0) e_rdy[w] = 1'b1;
    dx  = |(req_ready & req_valid);
    gid = oh2id(req_ready);
    rs  = rsp_valid;
    if (chk_en) begin
      chk("req_ready", req_ready, e_rdy);
      chk("rden", rden, e_rden);
      if (e_rden) chk("rdaddress", rdaddress, e_addr);
      chk("rsp_valid", rsp_valid, e_rv);
      if (e_rv) begin
        chk("rsp_id", rsp_id, e_id);
        chk("rsp_data", rsp_data, e_data);
      end
      chk("err_underflow", err, e_err);
    end
    if (!rst_n) begin
      q.delete();
      m_rr = 0; m_drain = DC; m_g1 = 0;
      e_rden = 0; e_rv = 0; e_err = 0; e_addr = '0; e_id = 0; e_data = '0;
    end else begin
      e_rv = 0;
      if (rd_valid && m_drain == 0) begin
        if (q.size() > 0) begin
          e_rv = 1; e_id = q.pop_front(); e_data = rddata;
        end else e_err = 1;
      end
      e_rden = elig && (w >= 0);
      if (e_rden) begin
        e_addr = addr[w];
        q.push_back(w);
        m_rr = (w + 1) % NR;
        if (w == 1) m_g1++;
      end
      if (m_drain > 0) m_drain--;
    end
  endtask

  task automatic tick();
    mem_drive();
    #1;
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic rand_addr();
    for (int g = 0; g < NR; g++) addr[g] = AW'($urandom);
  endtask

  task automatic idle(int n);
    req_valid = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int nz, nr, nx;
    rst_n = 0; lock = 1; req_valid = '1; rd_valid = 0; rddata = '0;
    for (int g = 0; g < NR; g++) addr[g] = '0;
    addr[2] = 16'h10;
    tick();
    chk_en = 1;
    tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rden", rden, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_err", err, 0);

    // drain window with requester 2 waiting and a stray return at cycle 5
    rst_n = 1; req_valid = 4'b0100;
    nz = 0; nr = 0;
    for (int i = 0; i < DC; i++) begin
      inject = (i == 5);
      tick();
      inject = 0;
      nz += dx; nr += rs;
    end
    chk("drain_no_grant", nz, 0);
    chk("drain_no_rsp", nr, 0);
    chk("drain_no_err", err, 0);
    tick();
    chk("first_grant_xfer", dx, 1);
    chk("first_grant_id", gid, 2);
    req_valid = '0;
    chk("issue_rden", rden, 1);
    chk("issue_addr", rdaddress, 16'h10);
    nr = 0;
    for (int i = 0; i < 13; i++) begin tick(); nr += rs; end
    chk("lat_no_early_rsp", nr, 0);
    chk("lat_rsp_valid", rsp_valid, 1);
    chk("lat_rsp_id", rsp_id, 2);

    // round robin: pointer sits at 3 after granting requester 2
    req_valid = '1; rand_addr();
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_order", gid, (3 + k) % NR);
    end
    for (int i = 0; i < 40; i++) tick();
    idle(20);

    // long latency saturates the outstanding limit
    lat = 24; req_valid = '1; rand_addr();
    nx = 0;
    for (int i = 0; i < 26; i++) begin tick(); nx += dx; end
    chk("full_issue_count", nx, MO);
    tick();
    chk("full_regrant", dx, 1);
    for (int i = 0; i < 40; i++) tick();
    idle(40);
    lat = 12;

    // lock loss with 5 reads in flight
    req_valid = '1; rand_addr();
    for (int i = 0; i < 5; i++) tick();
    lock = 0; nz = 0; nr = 0;
    for (int i = 0; i < 20; i++) begin tick(); nz += dx; nr += rs; end
    chk("lock_no_grant", nz, 0);
    chk("lock_retire", nr, 5);
    lock = 1;
    tick();
    chk("lock_resume", dx, 1);
    idle(20);

    // underflow
    inject = 1; tick(); inject = 0; tick();
    chk("uf_err", err, 1);
    chk("uf_no_rsp", rsp_valid, 0);
    nr = 0;
    for (int i = 0; i < 5; i++) begin tick(); nr += rs; end
    chk("uf_no_rsp_later", nr, 0);
    chk("uf_sticky", err, 1);

    // reset with 5 reads in flight; memory keeps returning
    req_valid = '1; rand_addr(); nx = 0;
    for (int i = 0; i < 5; i++) begin tick(); nx += dx; end
    chk("mr_issued", nx, 5);
    req_valid = '0;
    tick(); tick();
    rst_n = 0; tick(); tick();
    chk("mr_err_cleared", err, 0);
    rst_n = 1; nr = 0;
    for (int i = 0; i < 25; i++) begin tick(); nr += rs; end
    chk("mr_no_rsp", nr, 0);
    chk("mr_no_err", err, 0);

    // random traffic, normal latency
    for (int i = 0; i < 1500; i++) begin
      req_valid = NR'($urandom); rand_addr();
      lock = ($urandom_range(15) != 0);
      tick();
    end
    lock = 1; idle(40);
    lat = 20;
    for (int i = 0; i < 1000; i++) begin
      req_valid = NR'($urandom | $urandom); rand_addr();
      lock = ($urandom_range(31) != 0);
      tick();
    end
    lock = 1; idle(40);

`ifdef PKTBUF_RD_STATS_EN
    chk("stat_grants_r1", stat_grants[63:32], m_g1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
